// File: rtl/param_code_lock_if.sv
// Keypad/display bundle for param_code_lock: key strobes in, lock status and entry display out.
interface param_code_lock_if #(
  parameter int DIGITS = 4
);
  logic                  key_valid;
  logic [3:0]            key_value;
  logic                  unlocked;
  logic                  lockout;
  logic [2:0]            state;
  logic [4*DIGITS-1:0]   entry_digits;
  logic [3:0]            entry_cnt;
  logic [3:0]            fail_cnt;
  logic                  ok_pulse;
  logic                  err_pulse;

  modport master (
    output key_valid, key_value,
    input  unlocked, lockout, state, entry_digits, entry_cnt, fail_cnt, ok_pulse, err_pulse
  );

  modport slave (
    input  key_valid, key_value,
    output unlocked, lockout, state, entry_digits, entry_cnt, fail_cnt, ok_pulse, err_pulse
  );
endinterface

// File: rtl/param_code_lock.sv
// Keypad code lock with programmable code, failed-attempt lockout and optional entry idle timeout.
// Define CODE_LOCK_ENTRY_TIMEOUT_EN to enable the ENTRY/PROGRAM inactivity timeout.
module param_code_lock #(
  parameter int                  DIGITS       = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                  MAX_TRIES    = 3,
  parameter int                  LOCKOUT_CYC  = 1_250_000_000,
  parameter int                  TIMEOUT_CYC  = 625_000_000
) (
  input  logic               clk,
  input  logic               rst,
  param_code_lock_if.slave   bus
);

  localparam int EW = 4 * DIGITS;
  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYC - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(DIGITS - 1);
  localparam logic [3:0]    MAX_FAIL  = 4'(MAX_TRIES);

  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_PROGRAM  = 3'd4;
  localparam logic [2:0] S_LOCKOUT  = 3'd5;

  localparam logic [3:0] K_PROGRAM = 4'hA;
  localparam logic [3:0] K_CLEAR   = 4'hE;
  localparam logic [3:0] K_RELOCK  = 4'hF;

  logic [2:0]    state;
  logic [EW-1:0] code;
  logic [EW-1:0] entry_digits;
  logic [3:0]    entry_cnt;
  logic [3:0]    fail_cnt;
  logic          ok_pulse;
  logic          err_pulse;
  logic [LW-1:0] lock_cnt;

  logic          is_digit;
  logic          is_prog;
  logic          is_clear;
  logic          is_relock;
  logic          last_digit;
  logic [EW-1:0] entry_next;
  logic [3:0]    fail_next;
  logic          idle_expired;

  assign is_digit   = bus.key_valid && (bus.key_value <= 4'd9);
  assign is_prog    = bus.key_valid && (bus.key_value == K_PROGRAM);
  assign is_clear   = bus.key_valid && (bus.key_value == K_CLEAR);
  assign is_relock  = bus.key_valid && (bus.key_value == K_RELOCK);
  assign last_digit = (entry_cnt == LAST_IDX);
  assign entry_next = (entry_digits << 4) | EW'(bus.key_value);
  assign fail_next  = fail_cnt + 4'd1;

`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
  localparam int            IW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  logic [IW-1:0] idle_cnt;
  logic          waiting;

  assign waiting      = (state == S_ENTRY) || (state == S_PROGRAM);
  assign idle_expired = waiting && !bus.key_valid && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst || !waiting || bus.key_valid || idle_expired) idle_cnt <= '0;
    else                                                  idle_cnt <= idle_cnt + IW'(1);
  end
`else
  assign idle_expired = 1'b0;
`endif

  // NOTE: every register here is updated with <= so all branches see the pre-edge values;
  // the stored code is an ordinary register and must reset to DEFAULT_CODE like the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOCKED;
      code         <= DEFAULT_CODE;
      entry_digits <= '0;
      entry_cnt    <= '0;
      fail_cnt     <= '0;
      ok_pulse     <= 1'b0;
      err_pulse    <= 1'b0;
      lock_cnt     <= '0;
    end else begin
      ok_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        S_LOCKED: begin
          if (is_digit) begin
            entry_digits <= EW'(bus.key_value);
            entry_cnt    <= 4'd1;
            state        <= (DIGITS == 1) ? S_CHECK : S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (is_digit) begin
            entry_digits <= entry_next;
            entry_cnt    <= entry_cnt + 4'd1;
            if (last_digit) state <= S_CHECK;
          end else if (is_clear || idle_expired) begin
            entry_digits <= '0;
            entry_cnt    <= '0;
            state        <= S_LOCKED;
          end
        end
        S_CHECK: begin
          entry_digits <= '0;
          entry_cnt    <= '0;
          if (entry_digits == code) begin
            ok_pulse <= 1'b1;
            fail_cnt <= '0;
            state    <= S_UNLOCKED;
          end else begin
            err_pulse <= 1'b1;
            fail_cnt  <= fail_next;
            state     <= (fail_next == MAX_FAIL) ? S_LOCKOUT : S_LOCKED;
          end
        end
        S_UNLOCKED: begin
          if (is_relock) begin
            state <= S_LOCKED;
          end else if (is_prog) begin
            entry_digits <= '0;
            entry_cnt    <= '0;
            state        <= S_PROGRAM;
          end
        end
        S_PROGRAM: begin
          if (is_digit) begin
            if (last_digit) begin
              code         <= entry_next;
              entry_digits <= '0;
              entry_cnt    <= '0;
              state        <= S_UNLOCKED;
            end else begin
              entry_digits <= entry_next;
              entry_cnt    <= entry_cnt + 4'd1;
            end
          end else if (is_clear || is_relock || idle_expired) begin
            entry_digits <= '0;
            entry_cnt    <= '0;
            state        <= is_relock ? S_LOCKED : S_UNLOCKED;
          end
        end
        S_LOCKOUT: begin
          // Counter runs 0..LOCKOUT_CYC-1, so LOCKOUT is held for exactly LOCKOUT_CYC cycles.
          if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            fail_cnt <= '0;
            state    <= S_LOCKED;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: begin
          entry_digits <= '0;
          entry_cnt    <= '0;
          state        <= S_LOCKED;
        end
      endcase
    end
  end

  assign bus.state        = state;
  assign bus.unlocked     = (state == S_UNLOCKED) || (state == S_PROGRAM);
  assign bus.lockout      = (state == S_LOCKOUT);
  assign bus.entry_digits = entry_digits;
  assign bus.entry_cnt    = entry_cnt;
  assign bus.fail_cnt     = fail_cnt;
  assign bus.ok_pulse     = ok_pulse;
  assign bus.err_pulse    = err_pulse;

endmodule
